// File: rtl/acia_pkg.sv
// Shared types and constants for the ACIA receive stage: divider codes,
// receiver FSM states, status-register bit positions and the character payload.
package acia_pkg;

  typedef enum logic [1:0] {
    DIV1   = 2'b00,
    DIV16  = 2'b01,
    DIV64  = 2'b10,
    MRESET = 2'b11
  } div_e;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

  localparam int unsigned RDRF = 0;
  localparam int unsigned DCD  = 2;
  localparam int unsigned FE   = 4;
  localparam int unsigned OVRN = 5;
  localparam int unsigned PE   = 6;
  localparam int unsigned IRQ  = 7;

  localparam int unsigned CNT_W = 7;

  typedef struct packed {
    logic       pe;
    logic       fe;
    logic [7:0] data;
  } rx_char_t;

  // Ticks per bit cell for a divider code.
  function automatic logic [CNT_W-1:0] bit_ticks(input div_e d);
    case (d)
      DIV16:   return CNT_W'(16);
      DIV64:   return CNT_W'(64);
      default: return CNT_W'(1);
    endcase
  endfunction

endpackage

// File: rtl/acia_rx_sync.sv
// Multi-bit synchroniser with rising/falling edge detection on the
// synchronised value (edge outputs are combinational, one clk wide).
module acia_rx_sync #(
  parameter int unsigned WIDTH  = 1,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] async_i,
  output logic [WIDTH-1:0] sync_o,
  output logic [WIDTH-1:0] rise_c,
  output logic [WIDTH-1:0] fall_c
);

  logic [STAGES-1:0][WIDTH-1:0] stage_q, stage_d;
  logic [WIDTH-1:0]             prev_q, prev_d;

  always_comb begin
    stage_d = {stage_q[STAGES-2:0], async_i};
    prev_d  = stage_q[STAGES-1];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stage_q <= '0;
      prev_q  <= '0;
    end else begin
      stage_q <= stage_d;
      prev_q  <= prev_d;
    end
  end

  assign sync_o = stage_q[STAGES-1];
  assign rise_c = sync_o & ~prev_q;
  assign fall_c = ~sync_o & prev_q;

endmodule

// File: rtl/acia_rx.sv
// 6850-style ACIA receiver: ticks from rxc edges, frames async characters,
// flags and IRQ. Define ACIA_RX_FIFO_EN for a FIFO in place of the holding register.
module acia_rx
  import acia_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxc,
  input  logic       rxd,
  input  logic       dcd,
  input  logic [1:0] cfg_div,
  input  logic       cfg_bits8,
  input  logic       cfg_par_en,
  input  logic       cfg_par_odd,
  input  logic       cfg_rie,
  input  logic       rd_data,
  input  logic       rd_status,
  output logic [7:0] rx_data,
  output logic       rdrf,
  output logic       fe,
  output logic       pe,
  output logic       ovrn,
  output logic       dcd_flag,
  output logic       irq
);

  logic [2:0] sync_s, rise_s, fall_s;
  logic       tick_c, rxd_s, rxd_fall_c, dcd_s, dcd_rise_c, mreset_c;
  logic       unused_c;

  acia_rx_sync #(.WIDTH(3), .STAGES(SYNC_STAGES)) u_sync (
    .clk     (clk),
    .reset   (reset),
    .async_i ({dcd, rxd, rxc}),
    .sync_o  (sync_s),
    .rise_c  (rise_s),
    .fall_c  (fall_s)
  );

  assign tick_c     = rise_s[0];
  assign rxd_s      = sync_s[1];
  assign rxd_fall_c = fall_s[1];
  assign dcd_s      = sync_s[2];
  assign dcd_rise_c = rise_s[2];
  assign mreset_c   = (cfg_div == MRESET);
  assign unused_c   = ^{sync_s[0], rise_s[1], fall_s[0], fall_s[2], 1'(FIFO_DEPTH)};

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc_c, tgt_c;
  logic             hit_c;
  logic [2:0]       bitcnt_q, bitcnt_d;
  logic [7:0]       shift_q, shift_d;
  logic             par_q, par_d, pe_nx_q, pe_nx_d, done_q, done_d;
  rx_char_t         char_q, char_d;
  div_e             lat_div_q, lat_div_d;
  logic             lat_bits8_q, lat_bits8_d, lat_par_en_q, lat_par_en_d;
  logic             lat_par_odd_q, lat_par_odd_d;

  // START checks at mid-bit; later bits are one full cell apart.
  assign cnt_inc_c = cnt_q + CNT_W'(1);
  assign tgt_c     = (state_q == START) ? (bit_ticks(lat_div_q) >> 1) : bit_ticks(lat_div_q);
  assign hit_c     = tick_c && (cnt_inc_c == tgt_c);

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    bitcnt_d      = bitcnt_q;
    shift_d       = shift_q;
    par_d         = par_q;
    pe_nx_d       = pe_nx_q;
    done_d        = 1'b0;
    char_d        = char_q;
    lat_div_d     = lat_div_q;
    lat_bits8_d   = lat_bits8_q;
    lat_par_en_d  = lat_par_en_q;
    lat_par_odd_d = lat_par_odd_q;
    if (tick_c) cnt_d = hit_c ? '0 : cnt_inc_c;
    case (state_q)
      IDLE: begin
        cnt_d    = '0;
        bitcnt_d = '0;
        par_d    = 1'b0;
        pe_nx_d  = 1'b0;
        if ((cfg_div == DIV1) ? (tick_c && !rxd_s) : rxd_fall_c) begin
          lat_div_d     = div_e'(cfg_div);
          lat_bits8_d   = cfg_bits8;
          lat_par_en_d  = cfg_par_en;
          lat_par_odd_d = cfg_par_odd;
          state_d       = (cfg_div == DIV1) ? DATA : START;
        end
      end
      START: if (hit_c) state_d = rxd_s ? IDLE : DATA;
      DATA: if (hit_c) begin
        shift_d  = {rxd_s, shift_q[7:1]};
        par_d    = par_q ^ rxd_s;
        bitcnt_d = bitcnt_q + 3'd1;
        if (bitcnt_q == (lat_bits8_q ? 3'd7 : 3'd6)) state_d = lat_par_en_q ? PARITY : STOP;
      end
      PARITY: if (hit_c) begin
        pe_nx_d = par_q ^ rxd_s ^ lat_par_odd_q;
        state_d = STOP;
      end
      STOP: if (hit_c) begin
        done_d      = 1'b1;
        char_d.data = lat_bits8_q ? shift_q : {1'b0, shift_q[7:1]};
        char_d.fe   = ~rxd_s;
        char_d.pe   = lat_par_en_q & pe_nx_q;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Carrier loss or master reset abandons any character in flight.
    if (dcd_s || mreset_c) begin
      state_d = IDLE;
      cnt_d   = '0;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      bitcnt_q      <= '0;
      shift_q       <= '0;
      par_q         <= 1'b0;
      pe_nx_q       <= 1'b0;
      done_q        <= 1'b0;
      char_q        <= '0;
      lat_div_q     <= DIV1;
      lat_bits8_q   <= 1'b0;
      lat_par_en_q  <= 1'b0;
      lat_par_odd_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      bitcnt_q      <= bitcnt_d;
      shift_q       <= shift_d;
      par_q         <= par_d;
      pe_nx_q       <= pe_nx_d;
      done_q        <= done_d;
      char_q        <= char_d;
      lat_div_q     <= lat_div_d;
      lat_bits8_q   <= lat_bits8_d;
      lat_par_en_q  <= lat_par_en_d;
      lat_par_odd_q <= lat_par_odd_d;
    end
  end

  logic [7:0] rx_data_c;
  logic       rdrf_c, fe_c, pe_c;
  logic       ovrn_q, ovrn_d;

`ifdef ACIA_RX_FIFO_EN
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned PW = AW + 1;

  rx_char_t        mem_q [FIFO_DEPTH];
  rx_char_t        mem_d [FIFO_DEPTH];
  logic [AW:0]     wr_q, wr_d, rd_q, rd_d;
  logic            empty_c, full_c, pop_c, push_c;
  rx_char_t        head_c;

  assign empty_c = (wr_q == rd_q);
  assign full_c  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign pop_c   = rd_data && !empty_c;
  assign push_c  = done_q && (!full_c || pop_c);
  assign head_c  = mem_q[rd_q[AW-1:0]];

  always_comb begin
    mem_d  = mem_q;
    wr_d   = wr_q;
    rd_d   = rd_q;
    ovrn_d = ovrn_q;
    if (push_c) begin
      mem_d[wr_q[AW-1:0]] = char_q;
      wr_d                = wr_q + PW'(1);
    end
    if (pop_c) rd_d = rd_q + PW'(1);
    if (done_q && full_c && !pop_c) ovrn_d = 1'b1;
    else if (rd_data)               ovrn_d = 1'b0;
    if (mreset_c) begin
      wr_d   = '0;
      rd_d   = '0;
      ovrn_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= '0;
      wr_q   <= '0;
      rd_q   <= '0;
      ovrn_q <= 1'b0;
    end else begin
      mem_q  <= mem_d;
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      ovrn_q <= ovrn_d;
    end
  end

  assign rx_data_c = empty_c ? 8'h00 : head_c.data;
  assign rdrf_c    = !empty_c;
  assign fe_c      = !empty_c && head_c.fe;
  assign pe_c      = !empty_c && head_c.pe;
`else
  logic [7:0] rx_data_q, rx_data_d;
  logic       rdrf_q, rdrf_d, fe_q, fe_d, pe_q, pe_d;

  // A read in the completion clk frees the register, so the new character wins.
  always_comb begin
    rx_data_d = rx_data_q;
    rdrf_d    = rdrf_q;
    fe_d      = fe_q;
    pe_d      = pe_q;
    ovrn_d    = ovrn_q;
    if (done_q) begin
      if (!rdrf_q || rd_data) begin
        rx_data_d = char_q.data;
        fe_d      = char_q.fe;
        pe_d      = char_q.pe;
        rdrf_d    = 1'b1;
      end else begin
        ovrn_d = 1'b1;
      end
    end else if (rd_data) begin
      rdrf_d = 1'b0;
      fe_d   = 1'b0;
      pe_d   = 1'b0;
      ovrn_d = 1'b0;
    end
    if (mreset_c) begin
      rx_data_d = '0;
      rdrf_d    = 1'b0;
      fe_d      = 1'b0;
      pe_d      = 1'b0;
      ovrn_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_data_q <= '0;
      rdrf_q    <= 1'b0;
      fe_q      <= 1'b0;
      pe_q      <= 1'b0;
      ovrn_q    <= 1'b0;
    end else begin
      rx_data_q <= rx_data_d;
      rdrf_q    <= rdrf_d;
      fe_q      <= fe_d;
      pe_q      <= pe_d;
      ovrn_q    <= ovrn_d;
    end
  end

  assign rx_data_c = rx_data_q;
  assign rdrf_c    = rdrf_q;
  assign fe_c      = fe_q;
  assign pe_c      = pe_q;
`endif

  logic dcd_flag_q, dcd_flag_d, dcd_arm_q, dcd_arm_d, irq_q, irq_d;

  // Carrier flag clears only via status read then data read with carrier present.
  always_comb begin
    dcd_flag_d = dcd_flag_q;
    dcd_arm_d  = dcd_arm_q;
    if (rd_status && dcd_flag_q) dcd_arm_d = 1'b1;
    if (rd_data) begin
      if (dcd_arm_q && !dcd_s) dcd_flag_d = 1'b0;
      dcd_arm_d = 1'b0;
    end
    if (dcd_rise_c) dcd_flag_d = 1'b1;
    irq_d = cfg_rie & (rdrf_c | ovrn_q | dcd_flag_q);
    if (mreset_c) begin
      dcd_flag_d = 1'b0;
      dcd_arm_d  = 1'b0;
      irq_d      = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dcd_flag_q <= 1'b0;
      dcd_arm_q  <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      dcd_flag_q <= dcd_flag_d;
      dcd_arm_q  <= dcd_arm_d;
      irq_q      <= irq_d;
    end
  end

  assign rx_data  = rx_data_c;
  assign rdrf     = rdrf_c;
  assign fe       = fe_c;
  assign pe       = pe_c;
  assign ovrn     = ovrn_q;
  assign dcd_flag = dcd_flag_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_acia_rx.sv
// Directed bench for acia_rx: table of framed characters plus hand-written
// sequences for glitch, overrun, master reset, carrier loss and the FIFO build.
module tb_acia_rx;
  import acia_pkg::*;

  logic       clk = 1'b0, reset = 1'b1;
  logic       rxc = 1'b0, rxd = 1'b1, dcd = 1'b0;
  logic [1:0] cfg_div = 2'b00;
  logic       cfg_bits8 = 1'b1, cfg_par_en = 1'b0, cfg_par_odd = 1'b0, cfg_rie = 1'b0;
  logic       rd_data = 1'b0, rd_status = 1'b0;
  logic [7:0] rx_data;
  logic       rdrf, fe, pe, ovrn, dcd_flag, irq;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  acia_rx dut (
    .clk(clk), .reset(reset), .rxc(rxc), .rxd(rxd), .dcd(dcd),
    .cfg_div(cfg_div), .cfg_bits8(cfg_bits8), .cfg_par_en(cfg_par_en),
    .cfg_par_odd(cfg_par_odd), .cfg_rie(cfg_rie), .rd_data(rd_data),
    .rd_status(rd_status), .rx_data(rx_data), .rdrf(rdrf), .fe(fe), .pe(pe),
    .ovrn(ovrn), .dcd_flag(dcd_flag), .irq(irq)
  );

  typedef struct {
    logic [1:0] div;
    logic       bits8, par_en, par_odd;
    logic [7:0] data;
    logic       flip, stop;
    logic [7:0] exp_data;
    logic       exp_fe, exp_pe;
  } vec_t;

  vec_t tbl[7];

  function automatic logic [7:0] sts(input logic r, d, f, o, p, i);
    logic [7:0] s;
    s       = 8'h00;
    s[RDRF] = r;
    s[DCD]  = d;
    s[FE]   = f;
    s[OVRN] = o;
    s[PE]   = p;
    s[IRQ]  = i;
    return s;
  endfunction

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_sts(input string nm, input logic [7:0] exp);
    chk(nm, sts(rdrf, dcd_flag, fe, ovrn, pe, irq), exp);
  endtask

  // One rxc period: 4 clk low then 4 clk high; optional read strobe in the completion clk.
  task automatic tick(input bit rd_at_sample);
    repeat (4) @(posedge clk);
    #1 rxc = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk);
      #1;
      if (rd_at_sample && i == 3) rd_data = 1'b1;
      if (i == 4) rd_data = 1'b0;
    end
    rxc = 1'b0;
  endtask

  task automatic send_bit(input logic b, input int n, input bit rd_sample);
    int smp;
    smp = (n == 1) ? 1 : n / 2;
    rxd = b;
    for (int k = 1; k <= n; k++) tick(rd_sample && (k == smp));
  endtask

  task automatic send_char(input logic [1:0] div, input logic bits8, par_en, par_odd,
                           input logic [7:0] data, input logic flip, stop, input bit rd_done);
    int n;
    logic [7:0] d;
    logic p;
    cfg_div = div; cfg_bits8 = bits8; cfg_par_en = par_en; cfg_par_odd = par_odd;
    n = (div == 2'b00) ? 1 : (div == 2'b01) ? 16 : 64;
    d = bits8 ? data : {1'b0, data[6:0]};
    send_bit(1'b0, n, 1'b0);
    for (int i = 0; i < (bits8 ? 8 : 7); i++) send_bit(data[i], n, 1'b0);
    if (par_en) begin
      p = (^d) ^ par_odd ^ flip;
      send_bit(p, n, 1'b0);
    end
    send_bit(stop, n, rd_done);
    rxd = 1'b1;
  endtask

  task automatic pulse_rd();
    @(posedge clk); #1 rd_data = 1'b1;
    @(posedge clk); #1 rd_data = 1'b0;
  endtask

  task automatic pulse_status();
    @(posedge clk); #1 rd_status = 1'b1;
    @(posedge clk); #1 rd_status = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //          div    b8    pen   podd  data   flip  stop  exp    fe    pe
    tbl[0] = '{2'b00, 1'b1, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
    tbl[1] = '{2'b01, 1'b0, 1'b1, 1'b0, 8'h41, 1'b1, 1'b1, 8'h41, 1'b0, 1'b1};
    tbl[2] = '{2'b01, 1'b0, 1'b1, 1'b0, 8'h41, 1'b0, 1'b0, 8'h41, 1'b1, 1'b0};
    tbl[3] = '{2'b00, 1'b1, 1'b1, 1'b1, 8'h3C, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b0};
    tbl[4] = '{2'b00, 1'b0, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b1, 8'h7F, 1'b0, 1'b0};
    tbl[5] = '{2'b00, 1'b1, 1'b1, 1'b0, 8'h01, 1'b1, 1'b1, 8'h01, 1'b0, 1'b1};
    tbl[6] = '{2'b10, 1'b1, 1'b0, 1'b0, 8'hC3, 1'b0, 1'b1, 8'hC3, 1'b0, 1'b0};

    repeat (4) @(posedge clk);
    #1 reset = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("reset_rx_data", rx_data, 8'h00);
    chk_sts("reset_status", 8'h00);

    // Status is sampled right after the stop tick's high phase (4 clk after rxc rises).
    for (int v = 0; v < 7; v++) begin
      send_char(tbl[v].div, tbl[v].bits8, tbl[v].par_en, tbl[v].par_odd,
                tbl[v].data, tbl[v].flip, tbl[v].stop, 1'b0);
      @(negedge clk);
      chk($sformatf("vec%0d_data", v), rx_data, tbl[v].exp_data);
      chk_sts($sformatf("vec%0d_status", v), sts(1'b1, 1'b0, tbl[v].exp_fe, 1'b0, tbl[v].exp_pe, 1'b0));
      pulse_rd();
      @(negedge clk);
      chk_sts($sformatf("vec%0d_after_read", v), 8'h00);
      repeat (8) @(posedge clk);
    end

    // Master reset clears a loaded character.
    send_char(2'b00, 1'b1, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    chk("mreset_pre_data", rx_data, 8'h96);
    #1 cfg_div = 2'b11;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("mreset_data", rx_data, 8'h00);
    chk_sts("mreset_status", 8'h00);
    cfg_div = 2'b00;
    repeat (4) @(posedge clk);

    // Short low pulse at /16 is rejected at the mid-bit check.
    cfg_div = 2'b01; cfg_bits8 = 1'b1; cfg_par_en = 1'b0;
    send_bit(1'b0, 4, 1'b0);
    send_bit(1'b1, 12, 1'b0);
    send_bit(1'b1, 16, 1'b0);
    @(negedge clk);
    chk_sts("glitch_status", 8'h00);
    send_char(2'b01, 1'b1, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    chk("post_glitch_data", rx_data, 8'h5A);
    chk_sts("post_glitch_status", sts(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    pulse_rd();
    repeat (4) @(posedge clk);

`ifdef ACIA_RX_FIFO_EN
    for (int c = 1; c <= 5; c++)
      send_char(2'b00, 1'b1, 1'b0, 1'b0, 8'(c), 1'b0, 1'b1, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_sts("fifo_full_status", sts(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      chk($sformatf("fifo_head%0d", c), rx_data, 8'(c));
      chk($sformatf("fifo_rdrf%0d", c), 8'(rdrf), 8'h01);
      pulse_rd();
    end
    @(negedge clk);
    chk_sts("fifo_drained", 8'h00);
`else
    cfg_rie = 1'b1;
    send_char(2'b00, 1'b1, 1'b0, 1'b0, 8'h11, 1'b0, 1'b1, 1'b0);
    send_char(2'b00, 1'b1, 1'b0, 1'b0, 8'h22, 1'b0, 1'b1, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("ovrn_data", rx_data, 8'h11);
    chk_sts("ovrn_status", sts(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1));
    pulse_rd();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_sts("ovrn_cleared", 8'h00);
    send_char(2'b00, 1'b1, 1'b0, 1'b0, 8'h11, 1'b0, 1'b1, 1'b0);
    send_char(2'b00, 1'b1, 1'b0, 1'b0, 8'h22, 1'b0, 1'b1, 1'b1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rd_at_done_data", rx_data, 8'h22);
    chk_sts("rd_at_done_status", sts(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
    pulse_rd();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_sts("rd_at_done_cleared", 8'h00);
`endif

    // Carrier loss mid-character: abort, latch flag, conditional clear.
    cfg_rie = 1'b1;
    cfg_div = 2'b00; cfg_bits8 = 1'b1; cfg_par_en = 1'b0;
    send_bit(1'b0, 1, 1'b0);
    send_bit(1'b1, 1, 1'b0);
    send_bit(1'b0, 1, 1'b0);
    send_bit(1'b1, 1, 1'b0);
    dcd = 1'b1;
    repeat (6) @(posedge clk);
    for (int k = 0; k < 10; k++) send_bit(1'b1, 1, 1'b0);
    @(negedge clk);
    chk_sts("dcd_abort_status", sts(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1));
    pulse_status();
    pulse_rd();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("dcd_high_keep", 8'(dcd_flag), 8'h01);
    dcd = 1'b0;
    repeat (6) @(posedge clk);
    pulse_status();
    pulse_rd();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_sts("dcd_low_clear", 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
